// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words from a byte
// stream and writes them to instruction memory starting at BASE_ADDR.
module imem_loader #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
    parameter int                       MAX_WORDS     = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [10:0]              num_words,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [10:0]              word_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [11:0] MAX_W = 12'(MAX_WORDS);

    state_t                 state;
    state_t                 state_next;
    logic [10:0]            num_words_q;
    logic [1:0]             byte_idx;
    logic [DATA_WIDTH-1:0]  shreg;
    logic                   arm;
    logic                   empty_req;
    logic                   oversize;
    logic                   accept;
    logic                   last_word;
    logic [10:0]            count_inc;

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // byte_ready depends on state only, never on byte_valid.
    assign byte_ready = (state == S_COLLECT);
    assign wr_en      = (state == S_WRITE);
    assign busy       = (state == S_COLLECT) || (state == S_WRITE);
    assign done       = (state == S_DONE);

    assign arm       = start && ((state == S_IDLE) || (state == S_DONE));
    assign empty_req = (num_words == 11'd0);
    assign oversize  = ({1'b0, num_words} > MAX_W);
    assign accept    = byte_valid && byte_ready;
    assign count_inc = word_count + 11'd1;
    assign last_word = (count_inc == num_words_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    if (empty_req || oversize) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (accept && (byte_idx == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = last_word ? S_DONE : S_COLLECT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_words_q <= '0;
            word_count  <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            wr_data     <= '0;
            wr_addr     <= '0;
            error       <= 1'b0;
        end else begin
            if (arm) begin
                num_words_q <= num_words;
                word_count  <= '0;
                byte_idx    <= '0;
                error       <= oversize;
            end
            if (accept) begin
                shreg[{byte_idx, 3'b000} +: 8] <= byte_data;
                byte_idx                       <= byte_idx + 2'd1;
                // Latch the completed word and its address as the last byte lands.
                if (byte_idx == 2'd3) begin
                    wr_data <= {byte_data, shreg[DATA_WIDTH-9:0]};
                    wr_addr <= BASE_ADDR + ADDRESS_WIDTH'({word_count, 2'b00});
                end
            end
            if (state == S_WRITE) begin
                word_count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams compared against
// a word-assembly reference model through an expected-write queue.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic        prev_wr_en = 1'b0;
    logic [31:0] last_addr  = '0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: word i is bytes 4i..4i+3, first byte least significant.
    task automatic build_expected(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] word;
            logic [31:0] addr;
            word = 32'(stim_q[4*i]) + (32'(stim_q[4*i+1]) << 8)
                 + (32'(stim_q[4*i+2]) << 16) + (32'(stim_q[4*i+3]) << 24);
            addr = BASE + 32'(4 * i);
            exp_q.push_back({addr, word});
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_en_single_cycle", 64'(prev_wr_en), 64'd0);
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e[63:32]));
                check("wr_data", 64'(wr_data), 64'(e[31:0]));
                last_addr = wr_addr;
            end
        end
        prev_wr_en = wr_en;
    end

    // Driver tasks: all called at a negedge, return at a negedge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int budget;
        budget = 0;
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [10:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // gap_mode: 0 continuous, 1 idle cycle before every byte, 2 random idles.
    // glitch: byte index before which a stray start is pulsed (-1 for none).
    task automatic do_load(input int n, input int gap_mode, input int glitch);
        build_expected(n);
        pulse_start(11'(n));
        check("start_busy", 64'(busy), 64'd1);
        check("start_byte_ready", 64'(byte_ready), 64'd1);
        check("start_done_clear", 64'(done), 64'd0);
        check("start_error_clear", 64'(error), 64'd0);
        check("start_count_clear", 64'(word_count), 64'd0);
        for (int k = 0; k < 4 * n; k++) begin
            bit gap;
            if (k == glitch) begin
                byte_valid = 1'b0;
                pulse_start(11'd7);
                check("glitch_still_busy", 64'(busy), 64'd1);
            end
            gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            send_byte(stim_q[k], gap);
        end
        byte_valid = 1'b0;
        check("final_wr_en", 64'(wr_en), 64'd1);
        check("final_not_done_yet", 64'(done), 64'd0);
        @(negedge clk);
        check("final_done", 64'(done), 64'd1);
        check("final_busy_low", 64'(busy), 64'd0);
        check("final_ready_low", 64'(byte_ready), 64'd0);
        check("final_word_count", 64'(word_count), 64'(n));
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_fixed_two_words();
        stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-word load, continuous then toggling byte_valid.
        load_fixed_two_words();
        do_load(2, 0, -1);
        load_fixed_two_words();
        do_load(2, 1, -1);

        // Zero-length and oversize loads.
        pulse_start(11'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_error", 64'(error), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        pulse_start(11'd1025);
        check("oversize_done", 64'(done), 64'd1);
        check("oversize_error", 64'(error), 64'd1);
        check("oversize_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check("oversize_error_held", 64'(error), 64'd1);

        // Reset in the middle of a three-word load.
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        build_expected(3);
        pulse_start(11'd3);
        check("abort_error_cleared", 64'(error), 64'd0);
        for (int k = 0; k < 6; k++) send_byte(stim_q[k], 1'b0);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        check("abort_unwritten", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stim_q = '{8'h6F, 8'h00, 8'h00, 8'h00};
        do_load(1, 0, -1);

        // Stray start during COLLECT, then bytes offered while DONE.
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        do_load(3, 0, 5);
        byte_data = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1'b1;
            @(negedge clk);
            check("done_byte_ready", 64'(byte_ready), 64'd0);
            check("done_held", 64'(done), 64'd1);
        end
        byte_valid = 1'b0;

        // Full-capacity load with random bytes and random stalls.
        stim_q.delete();
        for (int i = 0; i < 4096; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        do_load(1024, 2, -1);
        check("full_last_addr", 64'(last_addr), 64'h0000_0000_BFC0_0FFC);
        check("full_error_low", 64'(error), 64'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes the instruction memory over its write port, the writer counterpart to the word-addressed instruction ROM that the fetch stage reads. It accepts a sized stream of bytes (from a UART receiver or testbench), assembles little-endian 32-bit instruction words, and issues one memory write per word starting at the reset vector 0xBFC00000. The core is held off until `done` rises.

## Interface
- `ADDRESS_WIDTH`, default 32: width of `wr_addr`.
- `DATA_WIDTH`, default 32: instruction word width; fixed at 4 bytes.
- `BASE_ADDR`, default 32'hBFC00000: byte address of word 0.
- `MAX_WORDS`, default 1024: memory capacity in words.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  one-cycle pulse that arms a load; sampled only in IDLE or DONE.
- `num_words`  in  11  words to load; sampled on the `start` cycle.
- `byte_valid`  in  1  `byte_data` holds a valid byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  memory write strobe, one cycle per word.
- `wr_addr`  out  ADDRESS_WIDTH  byte address of the write; always word-aligned.
- `wr_data`  out  DATA_WIDTH  assembled instruction word.
- `busy`  out  1  high in COLLECT and WRITE.
- `done`  out  1  load finished; held until the next accepted `start`.
- `error`  out  1  `num_words` exceeded `MAX_WORDS`; held until the next accepted `start`.
- `word_count`  out  11  words written in the current load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE/DONE + `start`:
  - `num_words == 0` -> DONE, `done` = 1, no writes.
  - `num_words > MAX_WORDS` -> DONE, `done` = 1, `error` = 1, no writes.
  - otherwise -> COLLECT; clear `word_count`, byte index, `done`, `error`.
- COLLECT: `byte_ready` = 1. A byte is accepted on each edge with `byte_valid && byte_ready`. Byte index k (0..3) goes to shift-register bits [8k+7:8k], so the first byte is the LSB. Acceptance of byte 3 -> WRITE.
- WRITE, exactly one cycle:
  - `wr_en` = 1, `byte_ready` = 0.
  - `wr_data` = assembled word.
  - `wr_addr` = `BASE_ADDR` + 4*`word_count`, computed modulo 2^ADDRESS_WIDTH.
  - Next edge: `word_count` += 1; -> DONE if the new count equals the latched `num_words`, else -> COLLECT with byte index 0.
- DONE: `done` = 1, `byte_ready` = 0. Bytes presented here are not consumed.
- `start` while `busy` is ignored. `start` in DONE re-arms and clears `done` and `error`.
- `byte_valid` low stalls COLLECT indefinitely; there is no timeout.
- `wr_addr` and `wr_data` may hold stale values when `wr_en` = 0. They are registered and reset to 0.

## Timing
- Reset, asynchronous: state IDLE. `byte_ready`, `wr_en`, `busy`, `done`, `error` = 0. `word_count`, `wr_addr`, `wr_data`, byte index = 0.
- Reset mid-load discards the partial word immediately. No write is issued after reset asserts.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to `byte_ready`.
- `start` on edge T -> `busy` = 1 and `byte_ready` = 1 in cycle T+1, or `done` = 1 in T+1 for the zero/oversize cases.
- Byte 3 accepted on edge N -> `wr_en` = 1 during cycle N+1 only -> `byte_ready` = 1 again in N+2, or `done` = 1 in N+2 for the final word.
- Peak throughput: 1 word per 5 cycles with `byte_valid` held high.
- Final word: `word_count` = `num_words` and `done` = 1 on the same edge that ends WRITE. `busy` drops on that edge.

## Test plan
- Reset, then `start` with `num_words` = 2; stream 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 continuously -> writes (0xBFC00000, 0x00000013) then (0xBFC00004, 0x00100093). Each `wr_en` is exactly 1 cycle. `done` rises 1 cycle after the second write, with `word_count` = 2.
- Same load with `byte_valid` toggling every other cycle -> identical write sequence. Byte order is preserved and no byte is lost or duplicated.
- `start` with `num_words` = 0 -> `done` = 1 next cycle, no `wr_en`. `start` with 1025 -> `done` = 1 and `error` = 1 next cycle, no `wr_en`.
- Assert `rst` after 6 bytes of a 3-word load -> outputs return to reset values asynchronously. A new `start` with 1 word and bytes 0x6F,0x00,0x00,0x00 writes 0x0000006F to 0xBFC00000.
- `start` pulsed during COLLECT -> ignored; count and addresses continue unchanged. Bytes offered in DONE -> `byte_ready` = 0 and no writes.
- `num_words` = 1024 with random bytes -> last write at 0xBFC00FFC. `word_count` = 1024. Every word compares equal to a reference model.
